// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register against a single-beat
// AXI4 read port and keeps a one-entry buffer of the last fetched word.
module ifetch_ctrl #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        dm_stall,
  output logic        pc_stall,
  output logic [31:0] inst_out,
  output logic [31:0] fetch_pc,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    StLookup,
    StAddr,
    StData,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        fetch_err_q, fetch_err_d;

  // Single-beat reads only: the ID and last flag carry no information.
  logic unused_axi_r;
  assign unused_axi_r = ^{rid, rlast};

  assign arid     = AXI_ID;
  assign arlen    = 4'd0;
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;
  assign inst_out = buf_inst_q;
  assign fetch_pc = buf_pc_q;
  assign fetch_err = fetch_err_q;

  // State, buffer and error-pulse registers; reset drops any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLookup;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'h0;
      buf_pc_q    <= 32'h0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state, buffer update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    fetch_err_d = 1'b0;
    arvalid     = 1'b0;
    araddr      = 32'h0;
    rready      = 1'b0;
    inst_valid  = 1'b0;
    pc_stall    = 1'b1;

    unique case (state_q)
      StLookup: begin
        if (buf_valid_q && (pc_in == buf_pc_q)) begin
          state_d = StDone;
        end else begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        // pc_in is frozen by pc_stall, so it doubles as the held address.
        arvalid = 1'b1;
        araddr  = pc_in;
        if (arready) begin
          state_d = StData;
        end
      end
      StData: begin
        rready = 1'b1;
        if (rvalid) begin
          buf_pc_d    = pc_in;
          buf_valid_d = 1'b1;
          if (rresp == 2'b00) begin
            buf_inst_d = rdata;
          end else begin
            buf_inst_d  = NOP_INST;
            fetch_err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        inst_valid = 1'b1;
        pc_stall   = dm_stall;
        if (!dm_stall) begin
          state_d = StLookup;
        end
      end
      default: begin
        state_d = StLookup;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed cycle table, reset corner case, then random
// traffic against a transaction-level model of PC register, memory and AXI slave.
module tb_ifetch_ctrl;

  logic        clk, rst;
  logic [31:0] pc_in;
  logic        dm_stall;
  logic        pc_stall;
  logic [31:0] inst_out, fetch_pc;
  logic        inst_valid, fetch_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  ifetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .dm_stall   (dm_stall),
    .pc_stall   (pc_stall),
    .inst_out   (inst_out),
    .fetch_pc   (fetch_pc),
    .inst_valid (inst_valid),
    .fetch_err  (fetch_err),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        dm;
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rdy;
    logic        e_iv;
    logic        e_ps;
    logic [31:0] e_inst;
    logic [31:0] e_fpc;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] pc, input logic dm, input logic ar,
                              input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                              input logic e_arv, input logic [31:0] e_addr,
                              input logic e_rdy, input logic e_iv, input logic e_ps,
                              input logic [31:0] e_inst, input logic [31:0] e_fpc,
                              input logic e_err);
    vec_t v;
    v.pc = pc; v.dm = dm; v.ar = ar; v.rv = rv; v.rd = rd; v.rr = rr;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_rdy = e_rdy; v.e_iv = e_iv;
    v.e_ps = e_ps; v.e_inst = e_inst; v.e_fpc = e_fpc; v.e_err = e_err;
    return v;
  endfunction

  localparam int NV = 30;
  vec_t vecs[NV];

  // Random-phase model state
  logic [31:0] pc, prev_pc, last_word, r_addr, prev_addr;
  logic        have_prev, r_pending, r_err, err_expect, prev_wait, hit;
  int          ar_count, cyc_since, hs_total;

  initial begin
    // Directed per-cycle table starting at reset release.
    vecs[0]  = mk(32'h0,  0, 1, 1, 32'h93, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(32'h0,  0, 1, 1, 32'h93, 0,  1, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(32'h0,  0, 1, 1, 32'h93, 0,  0, 0, 1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(32'h0,  0, 1, 1, 32'h93, 0,  0, 0, 0, 1, 0, 32'h93, 0, 0);
    vecs[4]  = mk(32'h40, 0, 0, 0, 32'h0,  0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(32'h40, 0, 0, 0, 32'h0,  0,  1, 32'h40, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(32'h40, 0, 0, 0, 32'h0,  0,  1, 32'h40, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(32'h40, 0, 0, 0, 32'h0,  0,  1, 32'h40, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(32'h40, 0, 1, 0, 32'h0,  0,  1, 32'h40, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(32'h40, 0, 0, 1, 32'h0010_0113, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 10; i < 15; i++)
      vecs[i] = mk(32'h40, 1, 0, 0, 32'h0, 0, 0, 0, 0, 1, 1, 32'h0010_0113, 32'h40, 0);
    vecs[15] = mk(32'h40, 0, 0, 0, 32'h0,  0,  0, 0, 0, 1, 0, 32'h0010_0113, 32'h40, 0);
    vecs[16] = mk(32'h44, 0, 1, 1, 32'h0020_0193, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[17] = mk(32'h44, 0, 1, 1, 32'h0020_0193, 0, 1, 32'h44, 0, 0, 1, 0, 0, 0);
    vecs[18] = mk(32'h44, 0, 1, 1, 32'h0020_0193, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[19] = mk(32'h44, 0, 1, 1, 32'h0020_0193, 0, 0, 0, 0, 1, 0, 32'h0020_0193, 32'h44, 0);
    vecs[20] = mk(32'h44, 0, 0, 0, 32'h0,  0,  0, 0, 0, 0, 1, 0, 0, 0);
    vecs[21] = mk(32'h44, 0, 0, 0, 32'h0,  0,  0, 0, 0, 1, 0, 32'h0020_0193, 32'h44, 0);
    vecs[22] = mk(32'h48, 0, 1, 1, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[23] = mk(32'h48, 0, 1, 1, 32'hDEAD_BEEF, 2, 1, 32'h48, 0, 0, 1, 0, 0, 0);
    vecs[24] = mk(32'h48, 0, 1, 1, 32'hDEAD_BEEF, 2, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[25] = mk(32'h48, 0, 1, 1, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 0, 32'h13, 32'h48, 1);
    vecs[26] = mk(32'hFFFF_FFFC, 0, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[27] = mk(32'hFFFF_FFFC, 0, 1, 1, 32'h1234_5678, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0);
    vecs[28] = mk(32'hFFFF_FFFC, 0, 1, 1, 32'h1234_5678, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    vecs[29] = mk(32'hFFFF_FFFC, 0, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 1, 0, 32'h1234_5678,
                  32'hFFFF_FFFC, 0);

    rst = 1'b1; pc_in = 32'h0; dm_stall = 1'b0; arready = 1'b0; rid = 4'h0;
    rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("arid", {28'b0, arid}, 32'd0);
    chk("arlen", {28'b0, arlen}, 32'd0);
    chk("arsize", {29'b0, arsize}, 32'd2);
    chk("arburst", {30'b0, arburst}, 32'd1);

    @(negedge clk);
    rst = 1'b0;
    hs_total = 0;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      pc_in = vecs[i].pc; dm_stall = vecs[i].dm; arready = vecs[i].ar;
      rvalid = vecs[i].rv; rdata = vecs[i].rd; rresp = vecs[i].rr;
      #2;
      chk($sformatf("v%0d_arvalid", i), {31'b0, arvalid}, {31'b0, vecs[i].e_arv});
      if (vecs[i].e_arv) chk($sformatf("v%0d_araddr", i), araddr, vecs[i].e_addr);
      chk($sformatf("v%0d_rready", i), {31'b0, rready}, {31'b0, vecs[i].e_rdy});
      chk($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
      chk($sformatf("v%0d_pc_stall", i), {31'b0, pc_stall}, {31'b0, vecs[i].e_ps});
      chk($sformatf("v%0d_fetch_err", i), {31'b0, fetch_err}, {31'b0, vecs[i].e_err});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_inst_out", i), inst_out, vecs[i].e_inst);
        chk($sformatf("v%0d_fetch_pc", i), fetch_pc, vecs[i].e_fpc);
      end
      if (arvalid && arready) hs_total++;
    end
    chk("table_ar_handshakes", hs_total, 32'd5);

    // Reset while a request is being presented.
    @(negedge clk);
    pc_in = 32'h100; dm_stall = 1'b0; arready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_arvalid", {31'b0, arvalid}, 32'd1);
    chk("pre_rst_araddr", araddr, 32'h100);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("async_rst_pc_stall", {31'b0, pc_stall}, 32'd1);
    chk("async_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; pc_in = 32'h0;
    #2;
    chk("post_rst_lookup_arvalid", {31'b0, arvalid}, 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst_refetch_arvalid", {31'b0, arvalid}, 32'd1);
    chk("post_rst_refetch_araddr", araddr, 32'h0);

    // Random traffic against the transaction-level model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pc = $urandom() & 32'hFFFF_FFFC;
    have_prev = 1'b0; r_pending = 1'b0; r_err = 1'b0; err_expect = 1'b0;
    prev_wait = 1'b0; prev_addr = 32'h0; last_word = 32'h0; r_addr = 32'h0;
    prev_pc = 32'h0; ar_count = 0; cyc_since = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      pc_in    = pc;
      dm_stall = ($urandom_range(3) == 0);
      arready  = ($urandom_range(2) != 0);
      rvalid   = r_pending && ($urandom_range(2) != 0);
      rdata    = r_pending ? mem_word(r_addr) : $urandom();
      rresp    = (r_pending && r_err) ? 2'b10 : 2'b00;
      #2;
      if (!inst_valid) begin
        chk("rnd_stall_when_not_valid", {31'b0, pc_stall}, 32'd1);
      end else begin
        chk("rnd_stall_follows_dm", {31'b0, pc_stall}, {31'b0, dm_stall});
      end
      chk("rnd_fetch_err", {31'b0, fetch_err}, {31'b0, err_expect});
      if (prev_wait) begin
        chk("rnd_arvalid_held", {31'b0, arvalid}, 32'd1);
        chk("rnd_araddr_held", araddr, prev_addr);
      end
      if (arvalid) chk("rnd_araddr_is_pc", araddr, pc);

      err_expect = 1'b0;
      if (rvalid && rready) begin
        r_pending  = 1'b0;
        last_word  = r_err ? 32'h0000_0013 : mem_word(r_addr);
        err_expect = r_err;
      end
      if (arvalid && arready) begin
        chk("rnd_no_overlap", {31'b0, r_pending}, 32'd0);
        r_pending = 1'b1;
        r_addr    = araddr;
        r_err     = ($urandom_range(5) == 0);
        ar_count++;
      end
      prev_wait = arvalid && !arready;
      prev_addr = araddr;

      cyc_since++;
      if (inst_valid && !pc_stall) begin
        hit = have_prev && (pc == prev_pc);
        chk("rnd_fetch_pc", fetch_pc, pc);
        chk("rnd_inst_out", inst_out, last_word);
        chk(hit ? "rnd_hit_no_ar" : "rnd_miss_one_ar", ar_count, hit ? 32'd0 : 32'd1);
        have_prev = 1'b1;
        prev_pc   = pc;
        ar_count  = 0;
        cyc_since = 0;
        case ($urandom_range(7))
          0, 1, 2: pc = pc;
          3, 4, 5: pc = pc + 32'd4;
          6:       pc = $urandom() & 32'hFFFF_FFFC;
          default: pc = 32'hFFFF_FFFC;
        endcase
      end
      if (cyc_since > 200) begin
        chk("rnd_handover_timeout", cyc_since, 32'd0);
        break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller that sequences the PC register against the instruction-side AXI4 read port.
- Issues one single-beat read per PC value and delivers the instruction word to IF/ID.
- Drives the PC stall input, so the PC advances only in the cycle an instruction is handed over and the data side is not stalled.
- Holds a one-entry last-fetch buffer, so a re-presented PC (hazard hold, branch to self) is served without an AXI transaction.

Parameters:
- AXI_ID, 4'd0: constant value driven on arid.
- NOP_INST, 32'h0000_0013: instruction substituted on a read error (addi x0,x0,0).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- pc_in  input  32  current PC register value
- dm_stall  input  1  data-side AXI stall; pipeline frozen
- pc_stall  output  1  to PC register; 1 = hold PC
- inst_out  output  32  fetched instruction
- fetch_pc  output  32  address of inst_out
- inst_valid  output  1  inst_out valid this cycle
- fetch_err  output  1  one-cycle pulse on a non-OKAY rresp
- arid  output  4  = AXI_ID
- araddr  output  32  read address
- arlen  output  4  constant 0
- arsize  output  3  constant 3'b010
- arburst  output  2  constant 2'b01
- arvalid  output  1  address valid
- arready  input  1  address ready
- rid  input  4  ignored
- rdata  input  32  read data
- rresp  input  2  read response
- rlast  input  1  ignored (single beat)
- rvalid  input  1  data valid
- rready  output  1  data ready

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values: state LOOKUP; buf_valid=0, buf_inst=0, buf_pc=0; arvalid=0, rready=0, inst_valid=0, fetch_err=0; pc_stall=1; inst_out=0, fetch_pc=0.
- State LOOKUP:
  - Compare pc_in with buf_pc.
  - If buf_valid and equal -> DONE (no AXI traffic).
  - Otherwise -> ADDR.
- State ADDR:
  - arvalid=1, araddr=pc_in.
  - pc_in is stable here because pc_stall=1.
  - arvalid/araddr stay held until arready; arready -> DATA.
- State DATA:
  - rready=1.
  - On rvalid: buf_pc<=pc_in, buf_valid<=1.
  - buf_inst<=rdata if rresp==2'b00; otherwise buf_inst<=NOP_INST and fetch_err pulses in the following cycle.
  - Then -> DONE.
- State DONE:
  - inst_valid=1, inst_out=buf_inst, fetch_pc=buf_pc.
  - pc_stall=dm_stall (combinational).
  - dm_stall=1: stay in DONE; outputs stable.
  - dm_stall=0: PC updates at this edge -> LOOKUP.
- pc_stall=1 in every state except DONE.
- inst_valid=0 outside DONE.
- Latency:
  - Miss, with arready and rvalid each arriving in the first cycle they are sampled: LOOKUP, ADDR, DATA, DONE = 4 cycles per instruction.
  - Hit: LOOKUP, DONE = 2 cycles.
- A PC hold caused by hazard logic (PC reloads the same value) always hits the buffer.
- Instruction memory is read-only, so the buffer is never invalidated except by reset.
- rvalid arriving in ADDR is not possible (no outstanding request) and is ignored; rready=0 there.
- Reset asserted mid-transaction: all outputs return to reset values immediately, including arvalid dropping. No outstanding transaction is tracked afterwards.
- dm_stall asserted in LOOKUP/ADDR/DATA has no effect on sequencing; it matters only in DONE.
- Address wrap: pc_in=32'hFFFF_FFFC is fetched normally; no special handling.

Test Plan:
- Reset release with pc_in=0; arready and rvalid given in the first cycle; rdata=32'h0000_0093 -> araddr=0 for one cycle; DONE reached 3 cycles after LOOKUP; inst_out=32'h0000_0093, fetch_pc=0, pc_stall low for exactly 1 cycle.
- arready withheld 3 cycles with pc_in=32'h40 -> arvalid high and araddr=32'h40 stable for 4 cycles; exactly one AR handshake.
- DONE with dm_stall=1 for 5 cycles -> inst_valid=1, pc_stall=1, inst_out unchanged throughout; pc_stall falls in the cycle dm_stall falls.
- After DONE, pc_in held at the same value 32'h44 -> no arvalid; inst_valid reasserts 1 cycle after LOOKUP with the buffered word.
- rresp=2'b10 with rdata=32'hDEAD_BEEF -> inst_out=32'h0000_0013; fetch_err high for exactly one cycle.
- rst asserted while in ADDR with arvalid high -> arvalid=0 and pc_stall=1 asynchronously; after release, buf_valid=0 forces a new fetch of pc_in.
